// File: rtl/icache_fill_ctrl.sv
`timescale 1ns/1ps
//-----------------------------------------------------------------------------
// icache_fill_ctrl
//
// Purpose:
//   Owns the write side of the instruction-cache tag/data arrays. It accepts
//   one refill line at a time, reads the set's valid bits to choose a victim
//   way, then writes tag, valid bit and line into that way. On a flush
//   request it walks every set and clears all valid bits.
//
// Optional build macro:
//   ICACHE_LFSR_VICTIM_EN - when defined, the victim used when all ways are
//   valid comes from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01)
//   instead of the round-robin pointer. Invalid-way priority is the same in
//   both builds.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   refill_valid_i/ready_o     refill handshake
//   refill_tag_i/idx_i/line_i  refill payload (captured on accept)
//   refill_done_o              one-cycle pulse when the line is written
//   flush_req_i                request to invalidate the whole cache
//   flush_done_o               one-cycle pulse on the last set of the walk
//   busy_o                     arrays owned by this block; fetch must stall
//   valid_bit_i                valid bits from tag memory (1-cycle latency)
//   tag_req_o, data_req_o      per-way memory requests
//   tag_we_o, data_we_o        write enables
//   flush_en_o                 flush enable to tag memory
//   valid_bit_o, cline_o,
//   tag_o, addr_o              write data / set index to the arrays
//-----------------------------------------------------------------------------
module icache_fill_ctrl #(
   parameter int ICACHE_N_WAY = 4,
   parameter int WAY_WIDHT    = 128,
   parameter int TAG_WIDHT    = 20,
   parameter int ADDR_WIDHT   = 6
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    refill_valid_i,
   output logic                    refill_ready_o,
   input  logic [TAG_WIDHT-1:0]    refill_tag_i,
   input  logic [ADDR_WIDHT-1:0]   refill_idx_i,
   input  logic [WAY_WIDHT-1:0]    refill_line_i,
   output logic                    refill_done_o,
   input  logic                    flush_req_i,
   output logic                    flush_done_o,
   output logic                    busy_o,
   input  logic [ICACHE_N_WAY-1:0] valid_bit_i,
   output logic [ICACHE_N_WAY-1:0] tag_req_o,
   output logic [ICACHE_N_WAY-1:0] data_req_o,
   output logic                    tag_we_o,
   output logic                    data_we_o,
   output logic                    flush_en_o,
   output logic                    valid_bit_o,
   output logic [WAY_WIDHT-1:0]    cline_o,
   output logic [TAG_WIDHT-1:0]    tag_o,
   output logic [ADDR_WIDHT-1:0]   addr_o
);

   localparam int WAY_IDX_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;
   localparam logic [ADDR_WIDHT-1:0] LAST_SET = '1;

   typedef enum logic [1:0] {IDLE, VB_RD, WRITE, FLUSH} state_t;

   state_t                  state;
   logic                    flush_pend;
   logic [ADDR_WIDHT-1:0]   flush_cnt;
   logic [TAG_WIDHT-1:0]    cap_tag;
   logic [ADDR_WIDHT-1:0]   cap_idx;
   logic [WAY_WIDHT-1:0]    cap_line;

   logic                    free_found;
   logic [WAY_IDX_W-1:0]    free_way;
   logic [WAY_IDX_W-1:0]    fallback_way;
   logic [WAY_IDX_W-1:0]    victim;
   logic [ICACHE_N_WAY-1:0] victim_oh;

   // Lowest-index invalid way; scanning downwards lets the lowest hit win.
   always_comb begin
      free_found = 1'b0;
      free_way   = '0;
      for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
         if (!valid_bit_i[w]) begin
            free_found = 1'b1;
            free_way   = WAY_IDX_W'(w);
         end
      end
   end

`ifdef ICACHE_LFSR_VICTIM_EN
   logic [7:0] lfsr;

   // Free-running; only its low bits matter, and only when the set is full.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lfsr <= 8'h01;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign fallback_way = lfsr[WAY_IDX_W-1:0];
`else
   localparam logic [WAY_IDX_W-1:0] LAST_WAY = WAY_IDX_W'(ICACHE_N_WAY - 1);
   logic [WAY_IDX_W-1:0] victim_ptr;

   // Advances only when it was actually used; survives flushes.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         victim_ptr <= '0;
      end else if (state == WRITE && !free_found) begin
         victim_ptr <= (victim_ptr == LAST_WAY) ? '0 : victim_ptr + 1'b1;
      end
   end

   assign fallback_way = victim_ptr;
`endif

   assign victim = free_found ? free_way : fallback_way;

   generate
      for (genvar gi = 0; gi < ICACHE_N_WAY; gi++) begin : g_victim_oh
         assign victim_oh[gi] = (victim == WAY_IDX_W'(gi));
      end
   endgenerate

   // Control state. A flush seen while a refill is in flight is remembered
   // and started straight after the write, without returning to IDLE.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         flush_pend <= 1'b0;
         flush_cnt  <= '0;
         cap_tag    <= '0;
         cap_idx    <= '0;
         cap_line   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_req_i || flush_pend) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end else if (refill_valid_i && refill_ready_o) begin
                  cap_tag  <= refill_tag_i;
                  cap_idx  <= refill_idx_i;
                  cap_line <= refill_line_i;
                  state    <= VB_RD;
               end
            end
            VB_RD: begin
               if (flush_req_i) begin
                  flush_pend <= 1'b1;
               end
               state <= WRITE;
            end
            WRITE: begin
               if (flush_req_i || flush_pend) begin
                  flush_pend <= 1'b1;
                  flush_cnt  <= '0;
                  state      <= FLUSH;
               end else begin
                  state <= IDLE;
               end
            end
            FLUSH: begin
               // Requests arriving during the walk are absorbed.
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == LAST_SET) begin
                  flush_pend <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array-side outputs are plain decodes of the current state.
   always_comb begin
      refill_ready_o = 1'b0;
      refill_done_o  = 1'b0;
      flush_done_o   = 1'b0;
      busy_o         = 1'b0;
      tag_req_o      = '0;
      data_req_o     = '0;
      tag_we_o       = 1'b0;
      data_we_o      = 1'b0;
      flush_en_o     = 1'b0;
      valid_bit_o    = 1'b0;
      cline_o        = '0;
      tag_o          = '0;
      addr_o         = '0;
      case (state)
         IDLE: begin
            refill_ready_o = ~flush_pend & ~flush_req_i;
         end
         VB_RD: begin
            busy_o    = 1'b1;
            tag_req_o = '1;
            addr_o    = cap_idx;
         end
         WRITE: begin
            busy_o        = 1'b1;
            tag_req_o     = victim_oh;
            data_req_o    = victim_oh;
            tag_we_o      = 1'b1;
            data_we_o     = 1'b1;
            valid_bit_o   = 1'b1;
            tag_o         = cap_tag;
            cline_o       = cap_line;
            addr_o        = cap_idx;
            refill_done_o = 1'b1;
         end
         FLUSH: begin
            busy_o       = 1'b1;
            tag_req_o    = '1;
            tag_we_o     = 1'b1;
            flush_en_o   = 1'b1;
            addr_o       = flush_cnt;
            flush_done_o = (flush_cnt == LAST_SET);
         end
         default: ;
      endcase
   end

endmodule
